// File: rtl/element_op_pkg.sv
// Shared types and helpers for the element-op matrix datapath family.
// Optional saturation build switch used by this family: ELEMENT_ADD_SAT_EN.
package element_op_pkg;

    localparam int DATA_W_DEF = 32;

    typedef logic [DATA_W_DEF-1:0] elem_t;

    // Returns {carry, sum} for one unsigned element add.
    function automatic logic [DATA_W_DEF:0] add_carry(
        input elem_t x,
        input elem_t y
    );
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage

// File: rtl/element_add_cell.sv
// One element adder with carry-out; clamps to all ones on carry
// when built with ELEMENT_ADD_SAT_EN, otherwise wraps.
module element_add_cell
    import element_op_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    logic [DATA_W:0] full;

    generate
        if (DATA_W == DATA_W_DEF) begin : g_pkg
            assign full = add_carry(a, b);
        end else begin : g_gen
            assign full = {1'b0, a} + {1'b0, b};
        end
    endgenerate

    assign carry = full[DATA_W];

`ifdef ELEMENT_ADD_SAT_EN
    assign sum = full[DATA_W] ? {DATA_W{1'b1}} : full[DATA_W-1:0];
`else
    assign sum = full[DATA_W-1:0];
`endif

endmodule

// File: rtl/element_add.sv
// Registered element-wise adder of two WIDTH x WIDTH matrices.
// Build with ELEMENT_ADD_SAT_EN for saturating instead of wrapping sums.
module element_add
    import element_op_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0]    a,
    input  logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0]    b,
    output logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0]    result,
    output logic                                       out_valid,
    output logic                                       overflow
);

    logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0] sum_next;
    logic [WIDTH*WIDTH-1:0]                  carries;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_row
            for (genvar j = 0; j < WIDTH; j++) begin : g_col
                element_add_cell #(
                    .DATA_W (DATA_W)
                ) u_cell (
                    .a     (a[i][j]),
                    .b     (b[i][j]),
                    .sum   (sum_next[i][j]),
                    .carry (carries[i*WIDTH+j])
                );
            end
        end
    endgenerate

    // Reset wins over a pair presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= sum_next;
                overflow <= |carries;
            end
        end
    end

endmodule

// File: tb/tb_element_add.sv
// Self-checking bench for element_add: table vectors, corner sequences
// and randomized traffic against a plain-arithmetic reference model.
module tb_element_add;

    localparam int W  = 8;
    localparam int DW = 32;

    typedef logic [0:W-1][0:W-1][DW-1:0] mat_t;

    typedef struct {
        string name;
        mat_t  a;
        mat_t  b;
        mat_t  exp_r;
        logic  exp_ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    mat_t a;
    mat_t b;
    mat_t result;
    logic out_valid;
    logic overflow;

    int nchecks = 0;
    int nerrors = 0;

    element_add #(.WIDTH(W), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .result    (result),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    mat_t m_r;
    logic m_v;
    logic m_ov;

    // Reference: each element summed in 64-bit arithmetic.
    task automatic ref_add(input mat_t x, input mat_t y,
                           output mat_t r, output logic ov);
        longint unsigned s;
        longint unsigned lim;
        lim = 64'h1_0000_0000;
        ov = 1'b0;
        r = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                s = longint'(x[i][j]) + longint'(y[i][j]);
                if (s >= lim) begin
                    ov = 1'b1;
`ifdef ELEMENT_ADD_SAT_EN
                    s = lim - 1;
`else
                    s = s - lim;
`endif
                end
                r[i][j] = s[DW-1:0];
            end
        end
    endtask

    task automatic chk(input string nm, input mat_t er,
                       input logic ev, input logic eov);
        int bi;
        int bj;
        bi = -1;
        bj = -1;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (bi < 0 && result[i][j] !== er[i][j]) begin
                    bi = i;
                    bj = j;
                end
        nchecks += 3;
        if (bi >= 0) begin
            nerrors++;
            $display("FAIL %s result[%0d][%0d] got=%h want=%h",
                     nm, bi, bj, result[bi][bj], er[bi][bj]);
        end
        if (out_valid !== ev) begin
            nerrors++;
            $display("FAIL %s out_valid got=%b want=%b", nm, out_valid, ev);
        end
        if (overflow !== eov) begin
            nerrors++;
            $display("FAIL %s overflow got=%b want=%b", nm, overflow, eov);
        end
    endtask

    // Drive one cycle, advance model, sample 1ns after the edge.
    task automatic cyc(input logic r, input logic v,
                       input mat_t x, input mat_t y);
        mat_t t;
        logic o;
        rst = r;
        in_valid = v;
        a = x;
        b = y;
        @(posedge clk);
        if (r) begin
            m_r = '0;
            m_v = 1'b0;
            m_ov = 1'b0;
        end else begin
            m_v = v;
            if (v) begin
                ref_add(x, y, t, o);
                m_r = t;
                m_ov = o;
            end
        end
        #1;
    endtask

    function automatic mat_t rnd_mat();
        mat_t m;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                m[i][j] = ($urandom_range(0, 1) == 1) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) :
                          32'($urandom);
        return m;
    endfunction

    function automatic mat_t fill(input logic [DW-1:0] v);
        mat_t m;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                m[i][j] = v;
        return m;
    endfunction

    vec_t tbl[4];
    mat_t za;
    mat_t zb;
    mat_t e;
    mat_t last;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        m_r = '0;
        m_v = 1'b0;
        m_ov = 1'b0;

        za = '0;
        zb = '0;
        za[0][1] = 1; zb[0][1] = 1;
        za[1][0] = 2; zb[1][0] = 2;
        za[1][1] = 3; zb[1][1] = 3;
        e = '0;
        e[0][1] = 2; e[1][0] = 4; e[1][1] = 6;
        tbl[0] = '{"sparse", za, zb, e, 1'b0};

        za = '0;
        zb = '0;
        za[7][7] = 32'hFFFF_FFFF;
        zb[7][7] = 32'h1;
        e = '0;
`ifdef ELEMENT_ADD_SAT_EN
        e[7][7] = 32'hFFFF_FFFF;
`endif
        tbl[1] = '{"ovf77", za, zb, e, 1'b1};

        tbl[2] = '{"nocarry", fill(32'h8000_0000), fill(32'h7FFF_FFFF),
                   fill(32'hFFFF_FFFF), 1'b0};
`ifdef ELEMENT_ADD_SAT_EN
        tbl[3] = '{"allcarry", fill(32'h8000_0000), fill(32'h8000_0000),
                   fill(32'hFFFF_FFFF), 1'b1};
`else
        tbl[3] = '{"allcarry", fill(32'h8000_0000), fill(32'h8000_0000),
                   fill(32'h0), 1'b1};
`endif

        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b1, fill(32'hFFFF_FFFF), fill(32'h5));
            chk("reset", '0, 1'b0, 1'b0);
        end

        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, tbl[k].a, tbl[k].b);
            chk(tbl[k].name, tbl[k].exp_r, 1'b1, tbl[k].exp_ov);
        end

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < W; i++)
                for (int j = 0; j < W; j++) begin
                    za[i][j] = 32'(k);
                    zb[i][j] = 32'(i * 8 + j);
                    e[i][j] = 32'(k + i * 8 + j);
                end
            cyc(1'b0, 1'b1, za, zb);
            chk("stream", e, 1'b1, 1'b0);
        end
        last = e;

        cyc(1'b0, 1'b0, rnd_mat(), rnd_mat());
        chk("hold1", last, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, rnd_mat(), rnd_mat());
        chk("hold2", last, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, tbl[1].a, tbl[1].b);
        chk("ovf_pre", tbl[1].exp_r, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, '0, '0);
        chk("ovf_hold", tbl[1].exp_r, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, rnd_mat(), rnd_mat());
        chk("rst_mid", '0, 1'b0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                rnd_mat(), rnd_mat());
            chk("random", m_r, m_v, m_ov);
        end

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
